// File: rtl/mem_access_stage_if.sv
// Data-memory valid/ready port between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_ready, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_ready, dmem_rdata
   );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores on the data-memory port, stalls upstream while
// an access is pending, and writes the MEM/WB register; also supplies EX/MEM forwarding data.
module mem_access_stage #(
   parameter  int unsigned REG_WIDTH  = 32,
   parameter  int unsigned REG_COUNT  = 32,
   parameter  int unsigned MEM_CTRL_W = 14,
   parameter  int unsigned MAX_WAIT   = 15,
   localparam int unsigned REG_BITS   = $clog2(REG_COUNT),
   localparam int unsigned EXC_W      = REG_BITS + 1 + MEM_CTRL_W + 3 * REG_WIDTH,
   localparam int unsigned WB_W       = REG_BITS + 1 + REG_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [EXC_W-1:0]     exc_mem_reg,
   input  logic                 hold,
   mem_access_stage_if.master   dmem,
   output logic                 mem_stall,
   output logic [REG_WIDTH-1:0] fwd_data,
   output logic [WB_W-1:0]      mem_wb_reg,
   output logic                 mem_fault
);

   localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_HELD
   } state_t;

   logic [REG_BITS-1:0]   rd;
   logic                  write_en;
   logic [MEM_CTRL_W-1:0] mem_ctrl;
   logic [REG_WIDTH-1:0]  alu_out;
   logic [REG_WIDTH-1:0]  store_data;
   logic [REG_WIDTH-1:0]  return_pc;

   assign {rd, write_en, mem_ctrl, alu_out, store_data, return_pc} = exc_mem_reg;

   logic       mem_read;
   logic       mem_write;
   logic [2:0] funct3;
   logic [1:0] wb_sel;
   logic [1:0] off;
   logic [6:0] unused_ctrl;

   assign mem_read    = mem_ctrl[13];
   assign mem_write   = mem_ctrl[12];
   assign funct3      = mem_ctrl[11:9];
   assign wb_sel      = mem_ctrl[8:7];
   assign unused_ctrl = mem_ctrl[6:0];
   assign off         = alu_out[1:0];

   logic                 is_mem;
   logic                 instr_valid;
   logic                 size_ok;
   logic                 access_ok;
   logic [3:0]           be;
   logic [REG_WIDTH-1:0] wdata;

   // Access size and alignment; illegal funct3 is folded into the misalign fault.
   always_comb begin
      is_mem      = mem_read | mem_write;
      instr_valid = write_en | is_mem;
      be          = '0;
      wdata       = store_data;
      size_ok     = 1'b0;
      case (funct3)
         3'b000, 3'b100: begin
            be      = 4'b0001 << off;
            wdata   = {4{store_data[7:0]}};
            size_ok = 1'b1;
         end
         3'b001, 3'b101: begin
            be      = off[1] ? 4'b1100 : 4'b0011;
            wdata   = {2{store_data[15:0]}};
            size_ok = ~off[0];
         end
         3'b010: begin
            be      = 4'hF;
            size_ok = (off == 2'b00);
         end
         default: size_ok = 1'b0;
      endcase
      access_ok = size_ok & ~(mem_read & mem_write) & ~(mem_write & funct3[2]);
   end

   logic [15:0]          lane;
   logic [REG_WIDTH-1:0] ld_val;
   logic [REG_WIDTH-1:0] wb_data;
   logic [WB_W-1:0]      retire_val;

   always_comb begin
      lane = 16'(dmem.dmem_rdata >> {off, 3'b000});
      case (funct3)
         3'b000:  ld_val = {{24{lane[7]}}, lane[7:0]};
         3'b001:  ld_val = {{16{lane[15]}}, lane};
         3'b010:  ld_val = dmem.dmem_rdata;
         3'b100:  ld_val = {24'h0, lane[7:0]};
         3'b101:  ld_val = {16'h0, lane};
         default: ld_val = '0;
      endcase
      case (wb_sel)
         2'd1:    wb_data = ld_val;
         2'd2:    wb_data = return_pc;
         default: wb_data = alu_out;
      endcase
      retire_val = {rd, write_en & ~mem_write, wb_data};
   end

   state_t          state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [WB_W-1:0]  mem_wb_reg_q, mem_wb_reg_d;
   logic             mem_fault_q, mem_fault_d;
   logic             req;
   logic             stall;
   state_t           after_retire;

   assign after_retire = hold ? ST_HELD : ST_IDLE;

   // Request and stall are combinational on dmem_ready so a same-cycle ready costs no stall;
   // HELD parks the retired instruction until EX/MEM advances so a store is never reissued.
   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      mem_wb_reg_d = '0;
      mem_fault_d  = mem_fault_q;
      req          = 1'b0;
      stall        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            wait_cnt_d = '0;
            if (is_mem && !access_ok) begin
               mem_fault_d = 1'b1;
               state_d     = after_retire;
            end else if (is_mem) begin
               req = 1'b1;
               if (dmem.dmem_ready) begin
                  mem_wb_reg_d = retire_val;
                  state_d      = after_retire;
               end else begin
                  stall      = 1'b1;
                  wait_cnt_d = CNT_W'(1);
                  state_d    = ST_WAIT;
               end
            end else if (instr_valid) begin
               mem_wb_reg_d = retire_val;
               state_d      = after_retire;
            end
         end
         ST_WAIT: begin
            req = 1'b1;
            if (dmem.dmem_ready) begin
               mem_wb_reg_d = retire_val;
               wait_cnt_d   = '0;
               state_d      = after_retire;
            end else if (wait_cnt_q == CNT_W'(MAX_WAIT)) begin
               mem_fault_d = 1'b1;
               wait_cnt_d  = '0;
               state_d     = after_retire;
            end else begin
               stall      = 1'b1;
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         ST_HELD: begin
            if (!hold) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         wait_cnt_q   <= '0;
         mem_wb_reg_q <= '0;
         mem_fault_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         mem_wb_reg_q <= mem_wb_reg_d;
         mem_fault_q  <= mem_fault_d;
      end
   end

   assign dmem.dmem_req   = req & ~rst;
   assign dmem.dmem_we    = mem_write;
   assign dmem.dmem_addr  = {alu_out[31:2], 2'b00};
   assign dmem.dmem_be    = be;
   assign dmem.dmem_wdata = wdata;

   assign mem_stall  = stall;
   assign fwd_data   = (wb_sel == 2'd2) ? return_pc : alu_out;
   assign mem_wb_reg = mem_wb_reg_q;
   assign mem_fault  = mem_fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against a transaction-level model
// of the stage's retire, stall, request and fault behaviour.
module tb_mem_access_stage;

   localparam int unsigned MAXW  = 4;
   localparam int unsigned EXC_W = 5 + 1 + 14 + 96;
   localparam int unsigned WB_W  = 5 + 1 + 32;

   typedef struct packed {
      logic [4:0]  rd;
      logic        we;
      logic        mr;
      logic        mw;
      logic [2:0]  f3;
      logic [1:0]  wbsel;
      logic [31:0] alu;
      logic [31:0] sd;
      logic [31:0] rpc;
   } instr_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [EXC_W-1:0] exc = '0;
   logic             hold = 1'b0;
   logic             mem_stall;
   logic [31:0]      fwd_data;
   logic [WB_W-1:0]  mem_wb_reg;
   logic             mem_fault;

   mem_access_stage_if dmem_if ();

   mem_access_stage #(
      .MAX_WAIT (MAXW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .exc_mem_reg (exc),
      .hold        (hold),
      .dmem        (dmem_if),
      .mem_stall   (mem_stall),
      .fwd_data    (fwd_data),
      .mem_wb_reg  (mem_wb_reg),
      .mem_fault   (mem_fault)
   );

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic        fault_exp = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [EXC_W-1:0] pack(input instr_t i);
      logic [6:0] junk;
      junk = 7'($urandom);
      return {i.rd, i.we, i.mr, i.mw, i.f3, i.wbsel, junk, i.alu, i.sd, i.rpc};
   endfunction

   function automatic int unsigned size_bytes(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit access_ok(input instr_t i);
      if (!(i.mr || i.mw)) return 1'b1;
      if (i.mr && i.mw) return 1'b0;
      if (i.f3 == 3'd3 || i.f3 == 3'd6 || i.f3 == 3'd7) return 1'b0;
      if (i.mw && i.f3[2]) return 1'b0;
      return (i.alu % size_bytes(i.f3)) == 0;
   endfunction

   function automatic logic [3:0] exp_be(input instr_t i);
      logic [7:0] m;
      m = 8'((1 << size_bytes(i.f3)) - 1) << i.alu[1:0];
      return m[3:0];
   endfunction

   function automatic logic [31:0] exp_wdata(input instr_t i);
      case (size_bytes(i.f3))
         1:       return {24'h0, i.sd[7:0]} * 32'h0101_0101;
         2:       return {16'h0, i.sd[15:0]} * 32'h0001_0001;
         default: return i.sd;
      endcase
   endfunction

   function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] word);
      int unsigned nb;
      logic [63:0] v;
      nb = size_bytes(f3);
      v  = ({32'h0, word} >> (8 * a[1:0])) & ((64'd1 << (8 * nb)) - 64'd1);
      if (!f3[2] && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
      return v[31:0];
   endfunction

   function automatic logic [WB_W-1:0] retire_of(input instr_t i, input logic [31:0] word);
      logic [31:0] d;
      if (i.wbsel == 2'd1)      d = load_val(i.f3, i.alu, word);
      else if (i.wbsel == 2'd2) d = i.rpc;
      else                      d = i.alu;
      return {i.rd, i.we & ~i.mw, d};
   endfunction

   task automatic apply_reset();
      rst = 1'b1;
      #1;
      check("rst_req", dmem_if.dmem_req, 0);
      check("rst_wb", mem_wb_reg, 0);
      check("rst_fault", mem_fault, 0);
      @(negedge clk);
      rst = 1'b0;
      exc = '0;
      hold = 1'b0;
      dmem_if.dmem_ready = 1'b0;
      @(posedge clk);
      #1;
      fault_exp = 1'b0;
   endtask

   // Present one instruction; lat is the cycle index (from first request) at which memory
   // answers, nhold the number of cycles hold stays asserted from the retire cycle on.
   task automatic run(input instr_t i, input int unsigned lat, input int unsigned nhold,
                      input logic [31:0] word);
      bit              mem, ok, valid, timeout, faulted;
      int unsigned     last, acc;
      logic [WB_W-1:0] ret;
      mem     = i.mr | i.mw;
      ok      = access_ok(i);
      valid   = i.we | mem;
      timeout = mem && ok && (lat > MAXW);
      last    = (mem && ok) ? (timeout ? MAXW : lat) : 0;
      faulted = mem && (!ok || timeout);
      acc     = 0;
      exc     = pack(i);
      hold    = (nhold != 0);
      dmem_if.dmem_rdata = word;
      for (int unsigned k = 0; k <= last; k++) begin
         dmem_if.dmem_ready = mem && ok && (k >= lat);
         @(negedge clk);
         if (k == 0) check("fwd", fwd_data, (i.wbsel == 2'd2) ? i.rpc : i.alu);
         check("req", dmem_if.dmem_req, mem && ok);
         check("stall", mem_stall, mem && ok && (k != last));
         if (k > 0) check("stall_bubble", mem_wb_reg, 0);
         if (mem && ok) begin
            check("addr", dmem_if.dmem_addr, {i.alu[31:2], 2'b00});
            check("we", dmem_if.dmem_we, i.mw);
            if (i.mw) begin
               check("be", dmem_if.dmem_be, exp_be(i));
               check("wdata", dmem_if.dmem_wdata, exp_wdata(i));
            end
         end
         if (dmem_if.dmem_req && dmem_if.dmem_ready) acc++;
         @(posedge clk);
         #1;
      end
      ret = (faulted || !valid) ? '0 : retire_of(i, word);
      fault_exp = fault_exp | faulted;
      check("retire", mem_wb_reg, ret);
      check("fault", mem_fault, fault_exp);
      for (int unsigned j = 1; j <= nhold; j++) begin
         hold = (j < nhold);
         dmem_if.dmem_ready = 1'b1;
         @(negedge clk);
         check("held_req", dmem_if.dmem_req, 0);
         check("held_stall", mem_stall, 0);
         if (dmem_if.dmem_req && dmem_if.dmem_ready) acc++;
         @(posedge clk);
         #1;
         check("held_bubble", mem_wb_reg, 0);
      end
      hold = 1'b0;
      dmem_if.dmem_ready = 1'b0;
      check("accepts", acc, (mem && ok && !timeout) ? 1 : 0);
      if (fault_exp) apply_reset();
   endtask

   function automatic instr_t mk(input logic [4:0] rd, input logic we, input logic mr,
                                 input logic mw, input logic [2:0] f3, input logic [1:0] wbsel,
                                 input logic [31:0] alu, input logic [31:0] sd);
      instr_t i;
      i.rd = rd; i.we = we; i.mr = mr; i.mw = mw; i.f3 = f3; i.wbsel = wbsel;
      i.alu = alu; i.sd = sd; i.rpc = $urandom;
      return i;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      instr_t i;
      int unsigned kind;
      dmem_if.dmem_ready = 1'b0;
      dmem_if.dmem_rdata = '0;
      @(posedge clk);
      #1;
      apply_reset();
      check("rst_stall", mem_stall, 0);

      i = mk(5'd5, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 32'h1234, 32'h0);
      run(i, 0, 0, 32'h0);
      check("add_const", mem_wb_reg, {5'd5, 1'b1, 32'h0000_1234});

      i = mk(5'd7, 1'b1, 1'b1, 1'b0, 3'b000, 2'd1, 32'h103, 32'h0);
      run(i, 2, 0, 32'h80FF_FFFF);
      check("lb_const", mem_wb_reg[31:0], 32'hFFFF_FF80);
      i.f3 = 3'b100;
      run(i, 2, 0, 32'h80FF_FFFF);
      check("lbu_const", mem_wb_reg[31:0], 32'h0000_0080);

      i = mk(5'd9, 1'b1, 1'b0, 1'b1, 3'b001, 2'd0, 32'h202, 32'hABCD_1234);
      run(i, 0, 0, 32'h0);
      check("sh_we0", mem_wb_reg[32], 0);

      i = mk(5'd3, 1'b0, 1'b0, 1'b1, 3'b010, 2'd0, 32'h300, 32'hCAFE_F00D);
      run(i, 1, 3, 32'h0);

      i = mk(5'd4, 1'b1, 1'b1, 1'b0, 3'b010, 2'd1, 32'h101, 32'h0);
      run(i, 0, 0, 32'h0);

      i = mk(5'd6, 1'b1, 1'b1, 1'b0, 3'b010, 2'd1, 32'h400, 32'h0);
      run(i, 10, 0, 32'h1111_2222);

      exc = pack(mk(5'd8, 1'b1, 1'b1, 1'b0, 3'b010, 2'd1, 32'h40, 32'h0));
      dmem_if.dmem_ready = 1'b0;
      @(negedge clk);
      check("rw_req0", dmem_if.dmem_req, 1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rw_stall1", mem_stall, 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rw_req_drop", dmem_if.dmem_req, 0);
      check("rw_wb", mem_wb_reg, 0);
      @(negedge clk);
      rst = 1'b0;
      exc = '0;
      @(posedge clk);
      #1;

      for (int n = 0; n < 300; n++) begin
         kind = $urandom_range(0, 7);
         i = mk(5'($urandom), 1'b1, 1'b0, 1'b0, 3'($urandom_range(0, 2)),
                ($urandom_range(0, 1) != 0) ? 2'd2 : 2'd0, $urandom, $urandom);
         if (kind == 0) begin
            i.we = 1'b0;
         end else if (kind >= 3 && kind <= 5) begin
            i.mr = 1'b1;
            i.we = 1'($urandom);
            i.wbsel = 2'd1;
            i.f3 = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(0, 2))
                                               : 3'($urandom_range(4, 5));
         end else if (kind >= 6) begin
            i.mw = 1'b1;
            i.we = 1'($urandom);
            i.wbsel = 2'd0;
         end
         if (($urandom_range(0, 15) == 0) && (i.mr || i.mw)) i.f3 = 3'($urandom);
         if ($urandom_range(0, 3) != 0) i.alu[1:0] = 2'b00;
         run(i, $urandom_range(0, 5), (i.we || i.mr || i.mw) ? $urandom_range(0, 3) : 0,
             $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
